// File: rtl/aurora_pkg.sv
// rtl/aurora_pkg.sv - shared Aurora framing types and default constants
package aurora_pkg;

  localparam int AXI_DATA_SIZE = 32;

  localparam int CC_PERIOD_DEFAULT = 5000;
  localparam int CC_LEN_DEFAULT    = 3;

  typedef enum logic [2:0] {
    OS_IDLE = 3'd0,
    OS_CC   = 3'd1,
    OS_SCP  = 3'd2,
    OS_ECP  = 3'd3,
    OS_DATA = 3'd4
  } ordered_sets_e;

endpackage

// File: rtl/cc_timer.sv
// rtl/cc_timer.sv - reload down-counter with enable and clear; one-cycle tick at zero
module cc_timer #(
  parameter int PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            W      = $clog2(PERIOD);
  localparam logic [W-1:0]  RELOAD = W'(PERIOD - 1);

  logic [W-1:0] count;

  assign tick = en & ~clr & (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RELOAD;
    end else if (clr) begin
      count <= RELOAD;
    end else if (en) begin
      if (count == '0) begin
        count <= RELOAD;
      end else begin
        count <= count - W'(1);
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - frames AXI-Stream payload with SCP/ECP, fills IDLE, inserts CC
module tx_frame_scheduler
  import aurora_pkg::*;
#(
  parameter int CC_PERIOD = CC_PERIOD_DEFAULT,
  parameter int CC_LEN    = CC_LEN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     link_up,
  input  logic [AXI_DATA_SIZE-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output ordered_sets_e            ordered_sets,
  output logic [AXI_DATA_SIZE-1:0] data_out,
  output logic                     cc_active
);

  localparam int               CNT_W       = $clog2(CC_LEN + 1);
  localparam logic [CNT_W-1:0] CC_CNT_LOAD = CNT_W'(CC_LEN - 1);

  logic             in_frame;
  logic             ecp_pending;
  logic             cc_due;
  logic [CNT_W-1:0] cc_cnt;
  logic             cc_tick;

  cc_timer #(
    .PERIOD(CC_PERIOD)
  ) u_cc_timer (
    .clk (clk),
    .rst (rst),
    .en  (link_up),
    .clr (~link_up),
    .tick(cc_tick)
  );

  assign s_axis_tready = link_up & in_frame & ~ecp_pending & ~cc_due & (cc_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ordered_sets <= OS_IDLE;
      data_out     <= '0;
      cc_active    <= 1'b0;
      in_frame     <= 1'b0;
      ecp_pending  <= 1'b0;
      cc_due       <= 1'b0;
      cc_cnt       <= '0;
    end else begin
      data_out  <= '0;
      cc_active <= 1'b0;
      if (!link_up) begin
        // Link loss aborts any open frame silently and truncates a running CC.
        ordered_sets <= OS_IDLE;
        in_frame     <= 1'b0;
        ecp_pending  <= 1'b0;
        cc_due       <= 1'b0;
        cc_cnt       <= '0;
      end else if (cc_cnt != '0) begin
        ordered_sets <= OS_CC;
        cc_active    <= 1'b1;
        cc_cnt       <= cc_cnt - CNT_W'(1);
      end else if (cc_due) begin
        ordered_sets <= OS_CC;
        cc_active    <= 1'b1;
        cc_cnt       <= CC_CNT_LOAD;
        cc_due       <= 1'b0;
      end else if (ecp_pending) begin
        ordered_sets <= OS_ECP;
        ecp_pending  <= 1'b0;
        in_frame     <= 1'b0;
      end else if (!in_frame && s_axis_tvalid) begin
        ordered_sets <= OS_SCP;
        in_frame     <= 1'b1;
      end else if (in_frame && s_axis_tvalid) begin
        ordered_sets <= OS_DATA;
        data_out     <= s_axis_tdata;
        if (s_axis_tlast) begin
          ecp_pending <= 1'b1;
        end
      end else begin
        ordered_sets <= OS_IDLE;
      end
      // A new CC request outranks the clear done above in the same cycle.
      if (cc_tick) begin
        cc_due <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb/tb_tx_frame_scheduler.sv - scoreboard bench for tx_frame_scheduler framing and CC insertion
module tb_tx_frame_scheduler;
  import aurora_pkg::*;

  localparam int TB_PERIOD = 16;
  localparam int TB_LEN    = 3;

  typedef struct {
    int                         cyc;
    ordered_sets_e              os;
    logic [AXI_DATA_SIZE-1:0]   data;
  } exp_t;

  typedef struct {
    logic [AXI_DATA_SIZE-1:0] data;
    logic                     last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     link_up = 1'b1;
  logic [AXI_DATA_SIZE-1:0] s_axis_tdata = '0;
  logic                     s_axis_tvalid = 1'b0;
  logic                     s_axis_tlast = 1'b0;
  logic                     s_axis_tready;
  ordered_sets_e            ordered_sets;
  logic [AXI_DATA_SIZE-1:0] data_out;
  logic                     cc_active;

  exp_t  sb[$];
  beat_t drv_q[$];
  int    cyc     = 0;
  int    lu_base = 0;
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  hs;

  tx_frame_scheduler #(
    .CC_PERIOD(TB_PERIOD),
    .CC_LEN   (TB_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .link_up      (link_up),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .ordered_sets (ordered_sets),
    .data_out     (data_out),
    .cc_active    (cc_active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // CC slots counted from the first edge after link_up (or reset release) takes effect.
  function automatic ordered_sets_e idle_or_cc(input int e);
    int d;
    d = e - lu_base;
    if (d >= TB_PERIOD + 1 && ((d - TB_PERIOD - 1) % TB_PERIOD) < TB_LEN) return OS_CC;
    return OS_IDLE;
  endfunction

  task automatic drv_update();
    s_axis_tvalid = (drv_q.size() != 0);
    s_axis_tdata  = (drv_q.size() != 0) ? drv_q[0].data : '0;
    s_axis_tlast  = (drv_q.size() != 0) ? drv_q[0].last : 1'b0;
  endtask

  task automatic load_frame(input int n, input logic [AXI_DATA_SIZE-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + AXI_DATA_SIZE'(i * 'h11);
      b.last = (i == n - 1);
      drv_q.push_back(b);
    end
    drv_update();
  endtask

  task automatic clk_tick();
    exp_t e;
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge clk);
    cyc++;
    #1;
    if (hs) void'(drv_q.pop_front());
    drv_update();
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq($sformatf("os@%0d", e.cyc), 64'(ordered_sets), 64'(e.os));
      check_eq($sformatf("data@%0d", e.cyc), 64'(data_out), 64'(e.data));
      check_eq($sformatf("cc_active@%0d", e.cyc), 64'(cc_active), 64'(e.os == OS_CC));
    end
  endtask

  task automatic step(input ordered_sets_e eos, input logic [AXI_DATA_SIZE-1:0] edata);
    exp_t e;
    e.cyc  = cyc + 1;
    e.os   = eos;
    e.data = edata;
    sb.push_back(e);
    clk_tick();
  endtask

  task automatic idle_until(input int e_last);
    while (cyc < e_last) step(idle_or_cc(cyc + 1), '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_os", 64'(ordered_sets), 64'(OS_IDLE));
    check_eq("rst_data", 64'(data_out), 64'h0);
    check_eq("rst_tready", 64'(s_axis_tready), 64'h0);
    check_eq("rst_cc_active", 64'(cc_active), 64'h0);
    rst = 1'b0;
    cyc = 0;
    lu_base = 0;

    // Idle link: first CC 17 edges after release, then every 16
    idle_until(52);

    // 3-word frame A1,B2,C3
    load_frame(3, 'hA1);
    check_eq("scp_tready", 64'(s_axis_tready), 64'h0);
    step(OS_SCP, '0);
    step(OS_DATA, 'hA1);
    step(OS_DATA, 'hB2);
    step(OS_DATA, 'hC3);
    step(OS_ECP, '0);
    step(OS_IDLE, '0);
    idle_until(77);

    // CC preempts after word 2 of 4
    load_frame(4, 'h10);
    step(OS_SCP, '0);
    step(OS_DATA, 'h10);
    step(OS_DATA, 'h21);
    for (int i = 0; i < TB_LEN; i++) begin
      check_eq($sformatf("cc_tready%0d", i), 64'(s_axis_tready), 64'h0);
      step(OS_CC, '0);
    end
    check_eq("post_cc_tready", 64'(s_axis_tready), 64'h1);
    step(OS_DATA, 'h32);
    step(OS_DATA, 'h43);
    step(OS_ECP, '0);
    step(OS_IDLE, '0);
    idle_until(93);

    // CC lands between last DATA and its ECP
    load_frame(2, 'h50);
    step(OS_SCP, '0);
    step(OS_DATA, 'h50);
    step(OS_DATA, 'h61);
    step(OS_CC, '0);
    step(OS_CC, '0);
    step(OS_CC, '0);
    step(OS_ECP, '0);
    step(OS_IDLE, '0);

    // Link drop after 2 of 5 words
    load_frame(5, 'h70);
    step(OS_SCP, '0);
    step(OS_DATA, 'h70);
    step(OS_DATA, 'h81);
    link_up = 1'b0;
    #1;
    check_eq("drop_tready", 64'(s_axis_tready), 64'h0);
    drv_q.delete();
    drv_update();
    step(OS_IDLE, '0);
    step(OS_IDLE, '0);
    step(OS_IDLE, '0);
    link_up = 1'b1;
    lu_base = cyc;
    load_frame(1, 'hE5);
    check_eq("relink_tready", 64'(s_axis_tready), 64'h0);
    step(OS_SCP, '0);
    step(OS_DATA, 'hE5);
    step(OS_ECP, '0);
    step(OS_IDLE, '0);
    idle_until(127);

    // Asynchronous reset mid-frame
    load_frame(3, 'h90);
    step(OS_SCP, '0);
    step(OS_DATA, 'h90);
    rst = 1'b1;
    #1;
    check_eq("arst_os", 64'(ordered_sets), 64'(OS_IDLE));
    check_eq("arst_data", 64'(data_out), 64'h0);
    check_eq("arst_tready", 64'(s_axis_tready), 64'h0);
    drv_q.delete();
    drv_update();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    lu_base = 0;
    idle_until(20);

    check_eq("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
